// File: rtl/mdio_slave.sv
// MDIO (clause 22) management responder: decodes MDC/MDIO frames into register read/write strobes.
// Define MDIO_SLAVE_PREAMBLE_SUPPRESS_EN to accept START after a single preamble one instead of 32.
module mdio_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  phy_addr,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_MIN = 6'd1;
`else
  localparam logic [5:0] PRE_MIN = 6'd32;
`endif

  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP} state_t;

  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic                   mdc_prev;
  logic                   mdc_s, mdio_s, rise, fall;

  // Synchronizers idle high so a bus held high through reset raises no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync  <= '1;
      mdio_sync <= '1;
      mdc_prev  <= 1'b1;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
      mdc_prev  <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign mdc_s  = mdc_sync[SYNC_STAGES-1];
  assign mdio_s = mdio_sync[SYNC_STAGES-1];
  assign rise   = mdc_s & ~mdc_prev;
  assign fall   = ~mdc_s & mdc_prev;

  state_t      state, state_d;
  logic [5:0]  pre_cnt, pre_d;
  logic [4:0]  bit_cnt, cnt_d;
  logic [15:0] sr, sr_d;
  logic [15:0] shift_in;
  logic        op_hi, op_hi_d, op_rd, op_rd_d, phy_ok, phy_ok_d;
  logic        mdio_o_d, mdio_t_d, wr_d, rd_d;
  logic [4:0]  addr_d;
  logic [15:0] wdata_d;

  assign shift_in = {sr[14:0], mdio_s};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      op_hi     <= 1'b0;
      op_rd     <= 1'b0;
      phy_ok    <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
    end else begin
      state     <= state_d;
      pre_cnt   <= pre_d;
      bit_cnt   <= cnt_d;
      sr        <= sr_d;
      op_hi     <= op_hi_d;
      op_rd     <= op_rd_d;
      phy_ok    <= phy_ok_d;
      mdio_o    <= mdio_o_d;
      mdio_t    <= mdio_t_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      reg_wr_en <= wr_d;
      reg_rd_en <= rd_d;
    end
  end

  // Frame decoder: rising edges advance the frame, falling edges only steer the MDIO driver.
  always_comb begin
    state_d  = state;
    pre_d    = pre_cnt;
    cnt_d    = bit_cnt;
    sr_d     = sr;
    op_hi_d  = op_hi;
    op_rd_d  = op_rd;
    phy_ok_d = phy_ok;
    mdio_o_d = mdio_o;
    mdio_t_d = mdio_t;
    addr_d   = reg_addr;
    wdata_d  = reg_wdata;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    // Read data arrives one cycle after the strobe; no MDC edge can coincide with it.
    if (reg_rd_en) sr_d = reg_rdata;
    case (state)
      IDLE: if (rise) begin
        if (mdio_s) begin
          if (pre_cnt != 6'd63) pre_d = pre_cnt + 6'd1;
        end else begin
          pre_d = '0;
          if (pre_cnt >= PRE_MIN) state_d = ST;
        end
      end
      ST: if (rise) begin
        cnt_d = '0;
        if (mdio_s) state_d = OP;
        else begin
          state_d = IDLE;
          pre_d   = '0;
        end
      end
      OP: if (rise) begin
        if (bit_cnt == 5'd0) begin
          op_hi_d = mdio_s;
          cnt_d   = 5'd1;
        end else begin
          cnt_d = '0;
          if (op_hi != mdio_s) begin
            op_rd_d = op_hi;
            state_d = PHYAD;
          end else begin
            state_d = IDLE;
            pre_d   = '0;
          end
        end
      end
      PHYAD: if (rise) begin
        sr_d  = shift_in;
        cnt_d = bit_cnt + 5'd1;
        if (bit_cnt == 5'd4) begin
          phy_ok_d = (shift_in[4:0] == phy_addr);
          cnt_d    = '0;
          state_d  = REGAD;
        end
      end
      REGAD: if (rise) begin
        sr_d  = shift_in;
        cnt_d = bit_cnt + 5'd1;
        if (bit_cnt == 5'd4) begin
          addr_d = shift_in[4:0];
          cnt_d  = '0;
          if (!phy_ok) state_d = SKIP;
          else begin
            state_d = TA;
            rd_d    = op_rd;
          end
        end
      end
      TA: begin
        if (rise) begin
          if (bit_cnt == 5'd1) begin
            cnt_d   = '0;
            state_d = op_rd ? RDATA : WDATA;
          end else begin
            cnt_d = 5'd1;
          end
        end else if (fall && op_rd && bit_cnt == 5'd1) begin
          mdio_t_d = 1'b0;
          mdio_o_d = 1'b0;
        end
      end
      RDATA: begin
        if (rise) cnt_d = bit_cnt + 5'd1;
        else if (fall) begin
          if (bit_cnt == 5'd16) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b1;
            cnt_d    = '0;
            pre_d    = '0;
            state_d  = IDLE;
          end else begin
            mdio_t_d = 1'b0;
            mdio_o_d = sr[15];
            sr_d     = {sr[14:0], 1'b0};
          end
        end
      end
      WDATA: if (rise) begin
        sr_d  = shift_in;
        cnt_d = bit_cnt + 5'd1;
        if (bit_cnt == 5'd15) begin
          wdata_d = shift_in;
          wr_d    = 1'b1;
          cnt_d   = '0;
          pre_d   = '0;
          state_d = IDLE;
        end
      end
      SKIP: if (rise) begin
        cnt_d = bit_cnt + 5'd1;
        if (bit_cnt == 5'd17) begin
          cnt_d   = '0;
          pre_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdio_slave.sv
// Randomized self-checking bench for mdio_slave: a bit-level MDIO master plus a frame-level expectation model.
module tb_mdio_slave;

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam int THR = 1;
`else
  localparam int THR = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  phy_addr;
  logic        mdc_i;
  logic        master_val, master_oe;
  logic        mdio_line;
  logic        mdio_o, mdio_t;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr_en, reg_rd_en;
  logic [15:0] reg_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [4:0]  q_wr_addr[$];
  logic [15:0] q_wr_data[$];
  logic [4:0]  q_rd_addr[$];
  int          wr_pulses = 0;
  int          rd_pulses = 0;
  logic [4:0]  last_waddr;
  logic [15:0] last_wdata;
  logic [15:0] rd_cap;
  logic        ta2_cap;

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up: responder wins when it drives.
  assign mdio_line = !mdio_t ? mdio_o : (master_oe ? master_val : 1'b1);

  mdio_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .phy_addr(phy_addr), .mdc_i(mdc_i), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe scoreboard: every strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        wr_pulses++;
        last_waddr = reg_addr;
        last_wdata = reg_wdata;
        if (q_wr_addr.size() == 0) checkOutput("unexpected_wr", 32'd1, 32'd0);
        else begin
          checkOutput("wr_addr", 32'(reg_addr), 32'(q_wr_addr.pop_front()));
          checkOutput("wr_data", 32'(reg_wdata), 32'(q_wr_data.pop_front()));
        end
      end
      if (reg_rd_en) begin
        rd_pulses++;
        if (q_rd_addr.size() == 0) checkOutput("unexpected_rd", 32'd1, 32'd0);
        else checkOutput("rd_addr", 32'(reg_addr), 32'(q_rd_addr.pop_front()));
      end
    end
  end

  // One MDC period: drive on the falling edge, check the line just before the rising edge.
  task automatic applyStimulus(input logic val, input logic oe, input logic exp_t, input logic exp_o,
                               input string tag, output logic line);
    @(negedge clk);
    mdc_i      = 1'b0;
    master_val = val;
    master_oe  = oe;
    repeat ($urandom_range(4, 6)) @(negedge clk);
    if (exp_t) checkOutput({tag, "_released"}, 32'(mdio_t), 32'd1);
    else       checkOutput({tag, "_driven"}, 32'({mdio_t, mdio_o}), 32'({1'b0, exp_o}));
    line  = mdio_line;
    mdc_i = 1'b1;
    repeat ($urandom_range(4, 6)) @(negedge clk);
  endtask

  // Frame-level model: decides from the frame fields alone whether it is answered and what the master sees.
  task automatic runFrame(input int pre_n, input logic st2, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] data, input int reset_at);
    logic accepted, op_ok, rd, answered, ln;
    logic [15:0] cap;
    cap      = '0;
    accepted = (pre_n >= THR);
    op_ok    = (op == 2'b01) || (op == 2'b10);
    rd       = (op == 2'b10);
    answered = accepted && st2 && op_ok && (phy == phy_addr);
    if (answered) begin
      if (rd) q_rd_addr.push_back(ra);
      else begin
        q_wr_addr.push_back(ra);
        q_wr_data.push_back(data);
      end
    end
    if (rd) reg_rdata = data;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "lead", ln);
    repeat (pre_n) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "pre", ln);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "st1", ln);
    applyStimulus(st2, 1'b1, 1'b1, 1'b1, "st2", ln);
    if (!st2) begin
      checkOutput("busy_bad_start", 32'(busy), 32'd0);
      return;
    end
    if (accepted) checkOutput("busy_frame", 32'(busy), 32'd1);
    applyStimulus(op[1], 1'b1, 1'b1, 1'b1, "op", ln);
    applyStimulus(op[0], 1'b1, 1'b1, 1'b1, "op", ln);
    if (!op_ok) begin
      checkOutput("busy_bad_op", 32'(busy), 32'd0);
      return;
    end
    for (int i = 4; i >= 0; i--) applyStimulus(phy[i], 1'b1, 1'b1, 1'b1, "phyad", ln);
    for (int i = 4; i >= 0; i--) applyStimulus(ra[i], 1'b1, 1'b1, 1'b1, "regad", ln);
    if (rd) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, "ta1", ln);
      applyStimulus(1'b1, 1'b0, !answered, 1'b0, "ta2", ln);
      ta2_cap = ln;
      for (int i = 15; i >= 0; i--) begin
        if (answered && (15 - i) == reset_at) begin
          @(negedge clk);
          mdc_i = 1'b0;
          repeat (5) @(negedge clk);
          checkOutput("pre_reset_driving", 32'(mdio_t), 32'd0);
          rst_n = 1'b0;
          #1;
          checkOutput("reset_release", 32'(mdio_t), 32'd1);
          checkOutput("reset_busy", 32'(busy), 32'd0);
          repeat (3) @(negedge clk);
          checkOutput("reset_strobes", 32'({reg_wr_en, reg_rd_en}), 32'd0);
          rst_n = 1'b1;
          return;
        end
        applyStimulus(1'b1, 1'b0, !answered, data[i], "rd_bit", ln);
        cap[i] = ln;
      end
      rd_cap = cap;
    end else begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "ta1", ln);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "ta2", ln);
      for (int i = 15; i >= 0; i--) applyStimulus(data[i], 1'b1, 1'b1, 1'b1, "wr_bit", ln);
    end
    checkOutput("wr_outstanding", 32'(q_wr_addr.size()), 32'd0);
    checkOutput("rd_outstanding", 32'(q_rd_addr.size()), 32'd0);
  endtask

  initial begin
    int w0, r0, pre_n, k;
    logic st2;
    logic [1:0] op;
    logic [4:0] phy;
    rst_n      = 1'b0;
    mdc_i      = 1'b1;
    master_val = 1'b1;
    master_oe  = 1'b1;
    phy_addr   = 5'd5;
    reg_rdata  = '0;
    repeat (4) @(negedge clk);
    checkOutput("rst_mdio_t", 32'(mdio_t), 32'd1);
    checkOutput("rst_mdio_o", 32'(mdio_o), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("rst_rd_en", 32'(reg_rd_en), 32'd0);
    checkOutput("rst_reg_addr", 32'(reg_addr), 32'd0);
    checkOutput("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    w0 = wr_pulses;
    runFrame(32, 1'b1, 2'b01, 5'd5, 5'd3, 16'hBEEF, -1);
    checkOutput("s_write_pulses", 32'(wr_pulses - w0), 32'd1);
    checkOutput("s_write_addr", 32'(last_waddr), 32'd3);
    checkOutput("s_write_data", 32'(last_wdata), 32'hBEEF);

    runFrame(32, 1'b1, 2'b10, 5'd5, 5'd2, 16'hA5C3, -1);
    checkOutput("s_read_ta2", 32'(ta2_cap), 32'd0);
    checkOutput("s_read_word", 32'(rd_cap), 32'hA5C3);

    w0 = wr_pulses; r0 = rd_pulses;
    runFrame(34, 1'b1, 2'b10, 5'd7, 5'd2, 16'h1357, -1);
    checkOutput("s_other_phy_strobes", 32'((wr_pulses - w0) + (rd_pulses - r0)), 32'd0);
    runFrame(32, 1'b1, 2'b01, 5'd5, 5'd9, 16'h0F0F, -1);
    checkOutput("s_after_other_phy", 32'(last_wdata), 32'h0F0F);

    w0 = wr_pulses;
    runFrame(31, 1'b1, 2'b01, 5'd5, 5'd4, 16'h1234, -1);
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
    checkOutput("s_pre31_pulses", 32'(wr_pulses - w0), 32'd1);
`else
    checkOutput("s_pre31_pulses", 32'(wr_pulses - w0), 32'd0);
`endif

    w0 = wr_pulses; r0 = rd_pulses;
    runFrame(32, 1'b1, 2'b11, 5'd5, 5'd1, 16'h0000, -1);
    checkOutput("s_op11_strobes", 32'((wr_pulses - w0) + (rd_pulses - r0)), 32'd0);

    runFrame(33, 1'b1, 2'b10, 5'd5, 5'd6, 16'h9C3A, 8);
    runFrame(32, 1'b1, 2'b10, 5'd5, 5'd6, 16'h6DB1, -1);
    checkOutput("s_after_reset_word", 32'(rd_cap), 32'h6DB1);

    phy_addr = 5'($urandom_range(0, 31));
    for (int n = 0; n < 30; n++) begin
      k     = $urandom_range(0, 9);
      pre_n = (k == 0) ? $urandom_range(1, 31) : $urandom_range(32, 36);
      st2   = (k == 1) ? 1'b0 : 1'b1;
      op    = (k == 2) ? ($urandom_range(0, 1) ? 2'b11 : 2'b00)
                       : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
      phy   = (k == 3) ? (phy_addr ^ 5'($urandom_range(1, 31))) : phy_addr;
      runFrame(pre_n, st2, op, phy, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)), -1);
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
